// File: rtl/pdp8_pkg.sv
// pdp8_pkg: shared PDP-8 widths and the instruction fetch unit state encoding
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif
package pdp8_pkg;
  localparam int PDP8_AW = `ADDR_WIDTH;
  localparam int PDP8_DW = `DATA_WIDTH;
  typedef enum logic [2:0] {IFU_LOAD, IFU_FETCH, IFU_WAIT, IFU_ISSUE, IFU_HOLD} ifu_state_e;
endpackage

// File: rtl/pdp8_ifu.sv
// pdp8_ifu: PDP-8 instruction fetch unit owning the PC and one outstanding memory read
module pdp8_ifu
  import pdp8_pkg::*;
#(
  parameter int ADDR_WIDTH = PDP8_AW,
  parameter int DATA_WIDTH = PDP8_DW,
  parameter int MEM_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  stall,
  input  logic                  new_pc_vld,
  input  logic [ADDR_WIDTH-1:0] new_pc,
  output logic                  ifu_rd_req,
  output logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  input  logic [DATA_WIDTH-1:0] ifu_rd_data,
  output logic [ADDR_WIDTH-1:0] PC_value,
  output logic [DATA_WIDTH-1:0] ifu_instr,
  output logic                  ifu_instr_vld
);
  if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_lat
    $error("pdp8_ifu: MEM_LAT must be within 1..7");
  end
  ifu_state_e            state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [2:0]            lat_cnt;
  assign ifu_rd_req    = state == IFU_FETCH;
  assign ifu_instr_vld = state == IFU_ISSUE;
  assign ifu_rd_addr   = pc;
  assign PC_value      = pc;
  // fetch sequencer: load PC, request, count out memory latency, issue, wait for execute
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= IFU_LOAD;
      pc        <= '0;
      lat_cnt   <= '0;
      ifu_instr <= '0;
    end else
      case (state)
        IFU_LOAD: begin
          pc    <= base_addr;
          state <= IFU_FETCH;
        end
        IFU_FETCH: begin
          lat_cnt <= 3'(MEM_LAT - 1);
          state   <= IFU_WAIT;
        end
        IFU_WAIT:
          if (lat_cnt == 3'd0) begin
            ifu_instr <= ifu_rd_data;
            state     <= IFU_ISSUE;
          end else
            lat_cnt <= lat_cnt - 3'd1;
        IFU_ISSUE: state <= IFU_HOLD;
        IFU_HOLD:
          if (!stall) begin
            pc    <= new_pc_vld ? new_pc : pc + 1'b1;
            state <= IFU_FETCH;
          end
        default: state <= IFU_LOAD;
      endcase
endmodule

// File: tb/tb_pdp8_ifu.sv
// tb_pdp8_ifu: vector-table and sequence checks of the fetch unit at MEM_LAT 1 and 3
module tb_pdp8_ifu;
  import pdp8_pkg::*;
  logic clk = 1'b0;
  logic rst1 = 1'b0, rst3 = 1'b0;
  logic [11:0] base_addr = 12'o0200;
  logic stall = 1'b0, new_pc_vld = 1'b0;
  logic [11:0] new_pc = '0;
  logic req1, req3, vld1, vld3;
  logic [11:0] addr1, addr3, pc1, pc3, data1, data3, ins1, ins3;
  logic [6:0] rq1 = '0, rq3 = '0;
  logic [11:0] aq1 = '0, aq3 = '0;
  logic prev1 = 1'b0, prev3 = 1'b0;
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  pdp8_ifu #(.MEM_LAT(1)) dut1 (
    .clk(clk), .reset_n(rst1), .base_addr(base_addr), .stall(stall),
    .new_pc_vld(new_pc_vld), .new_pc(new_pc), .ifu_rd_req(req1), .ifu_rd_addr(addr1),
    .ifu_rd_data(data1), .PC_value(pc1), .ifu_instr(ins1), .ifu_instr_vld(vld1)
  );
  pdp8_ifu #(.MEM_LAT(3)) dut3 (
    .clk(clk), .reset_n(rst3), .base_addr(base_addr), .stall(1'b0),
    .new_pc_vld(1'b0), .new_pc(12'o0000), .ifu_rd_req(req3), .ifu_rd_addr(addr3),
    .ifu_rd_data(data3), .PC_value(pc3), .ifu_instr(ins3), .ifu_instr_vld(vld3)
  );
  function automatic logic [11:0] mem_word(input logic [11:0] a);
    return a == 12'o0200 ? 12'o7402 : a ^ 12'o1234;
  endfunction
  // memory models: data is only meaningful exactly MEM_LAT cycles after the request
  always @(posedge clk) begin
    rq1 <= {rq1[5:0], req1};
    rq3 <= {rq3[5:0], req3};
    if (req1) aq1 <= addr1;
    if (req3) aq3 <= addr3;
  end
  assign data1 = rq1[0] ? mem_word(aq1) : 12'o5555;
  assign data3 = rq3[2] ? mem_word(aq3) : 12'o5555;
  // protocol monitor: no back-to-back requests, address known whenever execute is not stalling
  always @(negedge clk) begin
    if (req1 && prev1) begin total++; $display("FAIL req1_b2b act=1 req=0"); end
    if (req3 && prev3) begin total++; $display("FAIL req3_b2b act=1 req=0"); end
    if (!stall && $isunknown(addr1)) begin total++; $display("FAIL addr1_x act=%h req=known", addr1); end
    prev1 <= req1;
    prev3 <= req3;
  end
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s act=%0o req=%0o", n, act, exp);
  endtask
  typedef struct {
    logic st, nv; logic [11:0] np;
    logic rq; logic [11:0] a; logic v; logic [11:0] ins;
  } vec_t;
  vec_t tv[27];
  function automatic vec_t mk(input logic st, nv, input logic [11:0] np,
                              input logic rq, input logic [11:0] a, input logic v, input logic [11:0] ins);
    vec_t r;
    r.st = st; r.nv = nv; r.np = np; r.rq = rq; r.a = a; r.v = v; r.ins = ins;
    return r;
  endfunction
  task automatic run3(input string tag);
    #1;
    check({tag, "_c0_req"}, 32'(req3), 0);
    check({tag, "_c0_pc"}, 32'(pc3), 0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk); #1;
      check($sformatf("%s_c%0d_req", tag, c), 32'(req3), 32'(c == 1));
      check($sformatf("%s_c%0d_vld", tag, c), 32'(vld3), 32'(c == 5));
      check($sformatf("%s_c%0d_addr", tag, c), 32'(addr3), 12'o0200);
      if (c == 5) check({tag, "_instr"}, 32'(ins3), 12'o7402);
    end
  endtask
  initial begin
    tv[0]  = mk(0, 0, 0,       0, 12'o0000, 0, 12'o0000);
    tv[1]  = mk(0, 0, 0,       1, 12'o0200, 0, 12'o0000);
    tv[2]  = mk(0, 0, 0,       0, 12'o0200, 0, 12'o0000);
    tv[3]  = mk(0, 0, 0,       0, 12'o0200, 1, 12'o7402);
    tv[4]  = mk(0, 0, 0,       0, 12'o0200, 0, 12'o7402);
    tv[5]  = mk(0, 0, 0,       1, 12'o0201, 0, 12'o7402);
    tv[6]  = mk(0, 1, 12'o0400, 0, 12'o0201, 0, 12'o7402);
    tv[7]  = mk(1, 0, 0,       0, 12'o0201, 1, 12'o1035);
    for (int i = 8; i <= 12; i++) tv[i] = mk(1, 1, 12'o0400, 0, 12'o0201, 0, 12'o1035);
    tv[13] = mk(0, 0, 0,       0, 12'o0201, 0, 12'o1035);
    tv[14] = mk(0, 0, 0,       1, 12'o0202, 0, 12'o1035);
    tv[15] = mk(0, 0, 0,       0, 12'o0202, 0, 12'o1035);
    tv[16] = mk(0, 0, 0,       0, 12'o0202, 1, 12'o1036);
    tv[17] = mk(0, 1, 12'o7777, 0, 12'o0202, 0, 12'o1036);
    tv[18] = mk(0, 0, 0,       1, 12'o7777, 0, 12'o1036);
    tv[19] = mk(0, 0, 0,       0, 12'o7777, 0, 12'o1036);
    tv[20] = mk(0, 0, 0,       0, 12'o7777, 1, 12'o6543);
    tv[21] = mk(0, 0, 0,       0, 12'o7777, 0, 12'o6543);
    tv[22] = mk(0, 0, 0,       1, 12'o0000, 0, 12'o6543);
    tv[23] = mk(0, 0, 0,       0, 12'o0000, 0, 12'o6543);
    tv[24] = mk(0, 0, 0,       0, 12'o0000, 1, 12'o1234);
    tv[25] = mk(0, 1, 12'o0400, 0, 12'o0000, 0, 12'o1234);
    tv[26] = mk(0, 0, 0,       1, 12'o0400, 0, 12'o1234);
    repeat (3) @(negedge clk);
    check("rst_req", 32'(req1), 0);
    check("rst_vld", 32'(vld1), 0);
    check("rst_addr", 32'(addr1), 0);
    check("rst_instr", 32'(ins1), 0);
    rst1 = 1'b1;
    for (int i = 0; i < 27; i++) begin
      stall = tv[i].st; new_pc_vld = tv[i].nv; new_pc = tv[i].np;
      #1;
      check($sformatf("v%0d_req", i), 32'(req1), 32'(tv[i].rq));
      check($sformatf("v%0d_addr", i), 32'(addr1), 32'(tv[i].a));
      check($sformatf("v%0d_pc", i), 32'(pc1), 32'(tv[i].a));
      check($sformatf("v%0d_vld", i), 32'(vld1), 32'(tv[i].v));
      check($sformatf("v%0d_instr", i), 32'(ins1), 32'(tv[i].ins));
      @(negedge clk);
    end
    stall = 1'b0; new_pc_vld = 1'b0;
    rst3 = 1'b1;
    run3("lat3");
    @(negedge clk); #1;
    check("lat3_c7_req", 32'(req3), 1);
    check("lat3_c7_addr", 32'(addr3), 12'o0201);
    @(negedge clk);
    rst3 = 1'b0;
    #1;
    check("midrst_req", 32'(req3), 0);
    check("midrst_vld", 32'(vld3), 0);
    check("midrst_addr", 32'(addr3), 0);
    check("midrst_instr", 32'(ins3), 0);
    repeat (2) @(negedge clk);
    check("midrst_hold_vld", 32'(vld3), 0);
    rst3 = 1'b1;
    run3("refetch");
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
